// File: rtl/hcsr04_responder.sv
// Sensor-side HC-SR04 emulator: accepts a trigger pulse, waits out the burst
// delay, then answers with an echo whose width encodes distance_cm.
module hcsr04_responder #(
  parameter int unsigned TRIG_MIN_CYC = 500,
  parameter int unsigned ECHO_DELAY   = 10000,
  parameter int unsigned CYC_PER_CM   = 2900,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_CYC  = 1900000,
  parameter int unsigned HOLDOFF_CYC  = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       trigger,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic       trig_ignored
);

  localparam int CW = 22;
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] TRIG_MIN   = CW'(TRIG_MIN_CYC);
  localparam logic [CW-1:0] DELAY_LAST = CW'(ECHO_DELAY - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT    = CW'(TIMEOUT_CYC);
  localparam logic [8:0]    MAX_D      = 9'(MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRIG  = 3'd1,
    S_BURST = 3'd2,
    S_ECHO  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [8:0]      dist_q;
  logic [CW-1:0]   echo_last;
  logic            latch_dist;
  logic            echo_nx, busy_nx, err_nx, ign_nx;

  // Two-flop synchronizer plus one delay stage for rising-edge detection
  logic trig_m, trig_s, trig_s_d, trig_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_m   <= 1'b0;
      trig_s   <= 1'b0;
      trig_s_d <= 1'b0;
    end else begin
      trig_m   <= trigger;
      trig_s   <= trig_m;
      trig_s_d <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_s_d;

  // Echo length from the latched distance; zero or beyond range reads as no target
  logic [CW-1:0] prod, len_calc;
  assign prod     = CW'(32'(dist_q) * CYC_PER_CM);
  assign len_calc = (dist_q == 9'd0 || dist_q > MAX_D) ? TIMEOUT : prod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dist_q       <= '0;
      echo_last    <= '0;
      echo         <= 1'b0;
      busy         <= 1'b0;
      trig_err     <= 1'b0;
      trig_ignored <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      echo         <= echo_nx;
      busy         <= busy_nx;
      trig_err     <= err_nx;
      trig_ignored <= ign_nx;
      if (latch_dist)
        dist_q <= distance_cm;
      if (state == S_BURST && state_nx == S_ECHO)
        echo_last <= len_calc - ONE;
    end
  end

  // Next state: cnt is reloaded on every transition
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    latch_dist = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig_rise) begin
          state_nx = S_TRIG;
          cnt_nx   = ONE;
        end
      end
      S_TRIG: begin
        if (trig_s) begin
          if (cnt != CNT_MAX)
            cnt_nx = cnt + ONE;
        end else if (cnt >= TRIG_MIN) begin
          state_nx   = S_BURST;
          cnt_nx     = '0;
          latch_dist = 1'b1;
        end else begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      end
      S_BURST: begin
        if (cnt == DELAY_LAST) begin
          state_nx = S_ECHO;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      S_ECHO: begin
        if (cnt == echo_last) begin
          state_nx = S_HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so echo rises on the edge entering ECHO
  always_comb begin
    echo_nx = (state_nx == S_ECHO);
    busy_nx = (state_nx != S_IDLE);
    err_nx  = (state == S_TRIG) && !trig_s && (cnt < TRIG_MIN);
    ign_nx  = trig_rise &&
              (state == S_BURST || state == S_ECHO || state == S_HOLD);
  end

endmodule

// File: tb/tb_hcsr04_responder.sv
// Scoreboard bench for hcsr04_responder: stimulus queues expected echoes and
// pulses, an independent negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_hcsr04_responder;

  localparam int TMIN = 5, DLY = 20, CPC = 3, MAXC = 400, TMO = 2000, HOLD = 50;
  localparam int SYNC_LAT = 3; // two sync flops plus the FSM sampling edge

  logic       clk = 1'b0, reset_n = 1'b0, trigger = 1'b0;
  logic [8:0] distance_cm = '0;
  logic       echo, busy, trig_err, trig_ignored;

  hcsr04_responder #(
    .TRIG_MIN_CYC(TMIN), .ECHO_DELAY(DLY), .CYC_PER_CM(CPC),
    .MAX_CM(MAXC), .TIMEOUT_CYC(TMO), .HOLDOFF_CYC(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .trig_err(trig_err), .trig_ignored(trig_ignored)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int rise; int width; } echo_exp_t;
  echo_exp_t q_echo[$];
  int        q_err[$], q_ign[$];

  int   checks = 0, failures = 0, tmo_events = 0;
  logic rst_pend = 1'b0, rst_echo, rst_busy, rst_err, rst_ign;
  logic lb_pend = 1'b0, lb_led;
  int   lb_cm;
  logic done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pulse(input int n);
    @(posedge clk); #1 trigger = 1'b1;
    repeat (n) @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  // Called right after pulse(): cyc is the cycle of the trigger fall
  task automatic expect_echo(input int width);
    echo_exp_t e;
    e.rise  = cyc + DLY + SYNC_LAT;
    e.width = width;
    q_echo.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 6000) begin @(negedge clk); n++; end
    if (busy) begin
      tmo_events++;
      $display("FAIL timeout_%s busy still high after %0d cycles", name, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_echo(input string name);
    int n = 0;
    while (!echo && n < 200) begin @(negedge clk); n++; end
    if (!echo) begin
      tmo_events++;
      $display("FAIL timeout_%s echo never rose", name);
    end
  endtask

  // Minimal driver model for loopback: time the echo and threshold it at 100 cm
  task automatic driver_measure(input logic [8:0] d);
    int w = 0;
    distance_cm = d;
    pulse(10);
    expect_echo(int'(d) * CPC);
    wait_echo("loopback");
    while (echo && w < 5000) begin @(negedge clk); w++; end
    lb_cm   = w / CPC;
    lb_led  = (lb_cm < 100);
    lb_pend = 1'b1;
    wait_idle("loopback");
  endtask

  task automatic sample_reset_state();
    rst_echo = echo; rst_busy = busy; rst_err = trig_err; rst_ign = trig_ignored;
    rst_pend = 1'b1;
  endtask

  // Stimulus
  initial begin
    repeat (3) @(negedge clk);
    sample_reset_state();
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal; distance changes after the latch must not matter
    distance_cm = 9'd50; pulse(10); expect_echo(150);
    repeat (5) @(negedge clk); distance_cm = 9'd7;
    wait_idle("nominal");

    // Short triggers (3 and one below minimum), then minimum-width accepted
    q_err.push_back(1); pulse(3); wait_idle("short3");
    q_err.push_back(1); pulse(TMIN - 1); wait_idle("short4");
    distance_cm = 9'd20; pulse(TMIN); expect_echo(60); wait_idle("min_width");

    // Out of range and the largest in-range distance
    distance_cm = 9'd0;   pulse(10); expect_echo(TMO);  wait_idle("dist0");
    distance_cm = 9'd401; pulse(10); expect_echo(TMO);  wait_idle("dist401");
    distance_cm = 9'd400; pulse(10); expect_echo(1200); wait_idle("dist400");
    distance_cm = 9'd1;   pulse(10); expect_echo(3);    wait_idle("dist1");

    // Retrigger during echo plus a distance change mid-echo
    distance_cm = 9'd50; pulse(10); expect_echo(150);
    wait_echo("retrig");
    repeat (30) @(negedge clk);
    q_ign.push_back(1); pulse(10);
    distance_cm = 9'd100;
    wait_idle("retrig");

    // Asynchronous reset 100 cycles into a 150-cycle echo
    distance_cm = 9'd50; pulse(10);
    wait_echo("reset");
    repeat (100) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 sample_reset_state();
    repeat (5) @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);
    distance_cm = 9'd50; pulse(10); expect_echo(150); wait_idle("after_reset");

    driver_measure(9'd60);

    repeat (5) @(negedge clk);
    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    logic      in_echo = 1'b0, wait_busy = 1'b0;
    int        rise_c = 0, efall = 0;
    echo_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_pend) begin
        chk("reset_echo", rst_echo, 0);
        chk("reset_busy", rst_busy, 0);
        chk("reset_trig_err", rst_err, 0);
        chk("reset_trig_ignored", rst_ign, 0);
        rst_pend = 1'b0;
      end
      if (!reset_n) begin
        in_echo   = 1'b0;
        wait_busy = 1'b0;
      end else begin
        if (trig_err) begin
          chk("trig_err_expected", int'(q_err.size() > 0), 1);
          if (q_err.size() > 0) void'(q_err.pop_front());
        end
        if (trig_ignored) begin
          chk("trig_ignored_expected", int'(q_ign.size() > 0), 1);
          if (q_ign.size() > 0) void'(q_ign.pop_front());
        end
        if (echo && !in_echo) begin
          in_echo = 1'b1;
          rise_c  = cyc;
        end else if (!echo && in_echo) begin
          in_echo = 1'b0;
          chk("echo_expected", int'(q_echo.size() > 0), 1);
          if (q_echo.size() > 0) begin
            e = q_echo.pop_front();
            chk("echo_rise_cycle", rise_c, e.rise);
            chk("echo_width", cyc - rise_c, e.width);
          end
          wait_busy = 1'b1;
          efall     = cyc;
        end
        if (wait_busy && !busy) begin
          chk("holdoff_len", cyc - efall, HOLD);
          wait_busy = 1'b0;
        end
      end
      if (lb_pend) begin
        chk("loopback_cm", lb_cm, 60);
        chk("loopback_led", lb_led, 1);
        lb_pend = 1'b0;
      end
      if (done) begin
        chk("echo_queue_empty", q_echo.size(), 0);
        chk("err_queue_empty", q_err.size(), 0);
        chk("ign_queue_empty", q_ign.size(), 0);
        chk("wait_timeouts", tmo_events, 0);
        chk("echo_low_at_end", in_echo, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hcsr04_responder.md
Name: hcsr04_responder

Overview:
- Synthesizable emulator of the sensor side of the HC-SR04 ultrasonic ranging protocol: it receives the trigger pulse and answers with an echo pulse whose width encodes a programmed distance.
- Used as the far end of the ultrasonic driver for closed-loop simulation and FPGA loopback tests, where the driver's trigger feeds this block and this block's echo feeds the driver.
- Distance is supplied on a port, so a testbench or switches can sweep it without a physical sensor.

Parameters:
- TRIG_MIN_CYC, 500: minimum synchronized trigger high width accepted (10 us at 50 MHz).
- ECHO_DELAY, 10000: cycles between trigger fall and echo rise, emulating the 8-pulse burst (200 us).
- CYC_PER_CM, 2900: echo cycles per centimetre (58 us/cm at 50 MHz).
- MAX_CM, 400: largest in-range distance.
- TIMEOUT_CYC, 1900000: echo width for no-target / out-of-range (38 ms).
- HOLDOFF_CYC, 500000: dead time after echo fall before a new trigger is accepted (10 ms).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- trigger  input  1  trigger from driver, asynchronous to clk.
- distance_cm  input  9  emulated target distance in cm, sampled once per measurement.
- echo  output  1  echo pulse to driver, registered.
- busy  output  1  high whenever state is not IDLE.
- trig_err  output  1  one-cycle pulse when a trigger shorter than TRIG_MIN_CYC is rejected.
- trig_ignored  output  1  one-cycle pulse on a trigger rising edge seen while not IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE; all counters 0; echo, busy, trig_err and trig_ignored all 0; synchronizer flops 0. Echo drops immediately, even mid-pulse.
- trigger passes through a 2-FF synchronizer to give trig_s. trig_s_d is a one-cycle delayed copy used for edge detection. All timing below refers to trig_s.
- Single 22-bit counter cnt, reloaded at every state change.
- State machine:
  - IDLE: on a trig_s rising edge, go to TRIG_HIGH with cnt=1.
  - TRIG_HIGH: while trig_s=1, cnt increments and saturates at 2^22-1, so a stuck trigger never wraps. On trig_s=0:
    - if cnt >= TRIG_MIN_CYC: latch distance_cm into dist_q, go to BURST with cnt=0;
    - otherwise: pulse trig_err and return to IDLE.
  - BURST: go to ECHO when cnt = ECHO_DELAY-1. echo rises at the edge entering ECHO, which is ECHO_DELAY clocks after the edge that sampled trig_s low.
  - ECHO: echo=1. echo_len is computed on entry:
    - dist_q * CYC_PER_CM (22-bit product) if 1 <= dist_q <= MAX_CM;
    - TIMEOUT_CYC if dist_q = 0 or dist_q > MAX_CM.
    - Leave ECHO when cnt = echo_len-1, so echo is high for exactly echo_len cycles.
  - HOLDOFF: echo=0. Go to IDLE after HOLDOFF_CYC cycles.
- Triggers outside IDLE: a trig_s rising edge in BURST, ECHO or HOLDOFF pulses trig_ignored for one cycle and does not affect timing. A trigger still high when HOLDOFF ends is not accepted; only a new rising edge seen in IDLE starts a measurement.
- distance_cm changes after the latch in TRIG_HIGH have no effect on the measurement in progress.
- busy = (state != IDLE), registered alongside the state.
- trig_err and trig_ignored can never both pulse in the same cycle.
- Unused state encodings go to IDLE.

Test Plan:
Bench parameters: TRIG_MIN_CYC=5, ECHO_DELAY=20, CYC_PER_CM=3, MAX_CM=400, TIMEOUT_CYC=2000, HOLDOFF_CYC=50.
- Nominal: distance_cm=50, trigger high 10 cycles then low -> echo rises 20 cycles after the synchronized fall, stays high exactly 150 cycles, busy returns low 50 cycles after echo falls.
- Short trigger: trigger high 3 cycles -> one trig_err pulse, echo stays 0, busy returns low, next valid trigger measures normally.
- Out of range: distance_cm=0, then distance_cm=401 -> echo width 2000 cycles in both cases; distance_cm=400 -> echo width 1200 cycles.
- Retrigger while busy: second trigger pulse during ECHO -> one trig_ignored pulse, first echo width unchanged, no second echo; distance_cm changed mid-echo -> no effect.
- Reset mid-echo: reset_n low 100 cycles into a 150-cycle echo -> echo and busy drop without waiting for a clock edge; after release a new trigger gives a correct 150-cycle echo.
- Loopback: driver module connected with distance_cm=60 -> driver completes its cycle and its LED output matches its threshold comparison for a 180-cycle-scaled echo.
